// File: rtl/load_align_unit_pkg.sv
// Shared definitions for the load alignment unit.
//   - bus geometry (address / op widths)
//   - mem_op size codes and signedness codes
//   - controller state encoding
//   - size_bytes(): byte count for a size code
package load_align_unit_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned OP_W   = 5;

    typedef enum logic [1:0] {
        MEM_BYTE  = 2'd0,
        MEM_HALF  = 2'd1,
        MEM_WORD  = 2'd2,
        MEM_DWORD = 2'd3
    } mem_size_e;

    localparam logic MEM_UNSIGNED = 1'b0;
    localparam logic MEM_SIGNED   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_RSP0,
        S_REQ1,
        S_RSP1,
        S_OUT
    } state_e;

    function automatic int unsigned size_bytes(input mem_size_e size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Handshake/bus bundle of the load alignment unit.
//   req_*     : load request from the pipeline (valid/ready, addr, op)
//   mem_req_* : aligned bus read request (valid/ready, addr)
//   mem_rsp_* : bus read response (valid, data), no backpressure
//   rsp_*     : formatted result to the pipeline (valid/ready, data, err)
// Modport slave is the unit's view; master is the surrounding system's view.
interface load_align_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic                                    req_valid;
    logic                                    req_ready;
    logic [load_align_unit_pkg::ADDR_W-1:0]  req_addr;
    logic [load_align_unit_pkg::OP_W-1:0]    req_op;
    logic                                    mem_req_valid;
    logic                                    mem_req_ready;
    logic [load_align_unit_pkg::ADDR_W-1:0]  mem_req_addr;
    logic                                    mem_rsp_valid;
    logic [DATA_W-1:0]                       mem_rsp_data;
    logic                                    rsp_valid;
    logic                                    rsp_ready;
    logic [DATA_W-1:0]                       rsp_data;
    logic                                    rsp_err;

    modport slave (
        input  req_valid, req_addr, req_op, mem_req_ready,
               mem_rsp_valid, mem_rsp_data, rsp_ready,
        output req_ready, mem_req_valid, mem_req_addr,
               rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_addr, req_op, mem_req_ready,
               mem_rsp_valid, mem_rsp_data, rsp_ready,
        input  req_ready, mem_req_valid, mem_req_addr,
               rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/load_align_unit_extract.sv
// load_extract: combinational result formatter.
//   beats     : {beat1, beat0} as captured from the bus
//   off       : byte offset of the load inside beat0
//   size      : access size code
//   is_signed : sign-extend when set (DWORD never extends)
//   result    : selected bytes, sign- or zero-filled above the access size
module load_extract
    import load_align_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2*DATA_W-1:0]          beats,
    input  logic [$clog2(DATA_W/8)-1:0]  off,
    input  mem_size_e                    size,
    input  logic                         is_signed,
    output logic [DATA_W-1:0]            result
);
    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] shifted;
    logic              fill;

    always_comb begin
        shifted = DATA_W'(beats >> {off, 3'b000});
        fill    = 1'b0;
        case (size)
            MEM_BYTE:  fill = shifted[7];
            MEM_HALF:  fill = shifted[15];
            MEM_WORD:  fill = shifted[31];
            MEM_DWORD: fill = 1'b0;
            default:   fill = 1'b0;
        endcase
        if (is_signed == MEM_UNSIGNED) begin
            fill = 1'b0;
        end
        result = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            result[8*i +: 8] = (i < size_bytes(size)) ? shifted[8*i +: 8] : {8{fill}};
        end
    end
endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: turns byte-addressed loads into one or two aligned bus
// beats and returns the aligned, extended result.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : load_align_unit_if.slave (request, bus and result handshakes)
// Parameters: DATA_W (32/64) bus width; SPLIT_EN splits misaligned loads
// into two beats when 1, reports them as errors when 0.
module load_align_unit #(
    parameter int unsigned DATA_W   = 32,
    parameter bit          SPLIT_EN = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    load_align_unit_if.slave  bus
);
    import load_align_unit_pkg::*;

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  off_q;
    mem_size_e         size_q;
    logic              sign_q;
    logic              err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] beat0_q, beat1_q;
    logic [DATA_W-1:0] ext_data;

    mem_size_e         req_size;
    logic              req_illegal;
    logic              misaligned_q;
    logic              accept;
    logic              req_ready, mem_req_valid, rsp_valid;

    function automatic logic crosses(input logic [OFF_W-1:0] off, input mem_size_e size);
        return (32'(off) + size_bytes(size)) > NB;
    endfunction

    assign req_size     = mem_size_e'(bus.req_op[1:0]);
    assign req_illegal  = (req_size == MEM_DWORD && DATA_W == 32) ||
                          (!SPLIT_EN && crosses(bus.req_addr[OFF_W-1:0], req_size));
    assign misaligned_q = crosses(off_q, size_q);
    assign accept       = (state_q == S_IDLE) && bus.req_valid;

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        rsp_valid     = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = req_illegal ? S_OUT : S_REQ0;
                end
            end
            S_REQ0: begin
                mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = S_RSP0;
            end
            S_RSP0: begin
                if (bus.mem_rsp_valid) state_d = misaligned_q ? S_REQ1 : S_OUT;
            end
            S_REQ1: begin
                mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = S_RSP1;
            end
            S_RSP1: begin
                if (bus.mem_rsp_valid) state_d = S_OUT;
            end
            S_OUT: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            off_q      <= '0;
            size_q     <= MEM_BYTE;
            sign_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            beat0_q    <= '0;
            beat1_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                off_q      <= bus.req_addr[OFF_W-1:0];
                size_q     <= req_size;
                sign_q     <= (bus.req_op[2] == MEM_SIGNED);
                err_q      <= req_illegal;
                mem_addr_q <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
            if (state_q == S_RSP0 && bus.mem_rsp_valid) begin
                beat0_q <= bus.mem_rsp_data;
                // second beat address prepared here so REQ1 presents it stable from its first cycle
                if (misaligned_q) mem_addr_q <= mem_addr_q + ADDR_W'(NB);
            end
            if (state_q == S_RSP1 && bus.mem_rsp_valid) begin
                beat1_q <= bus.mem_rsp_data;
            end
        end
    end

    load_extract #(.DATA_W(DATA_W)) u_extract (
        .beats     ({beat1_q, beat0_q}),
        .off       (off_q),
        .size      (size_q),
        .is_signed (sign_q),
        .result    (ext_data)
    );

    // beats are frozen in OUT, so the formatted result is stable until rsp_ready
    assign bus.req_ready     = req_ready;
    assign bus.mem_req_valid = mem_req_valid;
    assign bus.mem_req_addr  = mem_addr_q;
    assign bus.rsp_valid     = rsp_valid;
    assign bus.rsp_data      = (state_q == S_OUT && !err_q) ? ext_data : '0;
    assign bus.rsp_err       = (state_q == S_OUT) && err_q;
endmodule

// File: tb/tb_load_align_unit.sv
`timescale 1ns/1ps
// Scoreboard agent: pushes expected results, bus addresses and memory beats;
// the monitor pops and compares.
module lau_agent #(
  parameter int unsigned W = 32,
  parameter string       N = "agent"
) (
  input logic         clk,
  load_align_unit_if  vif
);

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
  } rsp_t;

  int          compared   = 0;
  int          mismatched = 0;
  rsp_t        exp_q[$];
  logic [31:0] adr_q[$];
  logic [63:0] beat_q[$];
  bit          stray = 1'b0;
  time         t_acc = 0;
  int          lat   = 0;
  bit          seen  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s %s: got %h, required %h", N, name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (vif.req_valid && vif.req_ready) t_acc = $time;
    if (vif.rsp_valid && !seen) begin
      seen = 1'b1;
      lat  = int'(($time - t_acc) / 10);
    end
    if (vif.rsp_valid && vif.rsp_ready) begin
      seen = 1'b0;
      check("rsp expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_data", 64'(vif.rsp_data), e.data);
        check("rsp_err", 64'(vif.rsp_err), 64'(e.err));
        if (e.lat != 0) check("latency", 64'(lat), 64'(e.lat));
      end
    end
    if (vif.mem_req_valid && vif.mem_req_ready) begin
      check("bus req expected", 64'(adr_q.size() != 0), 64'd1);
      if (adr_q.size() != 0) check("mem_req_addr", 64'(vif.mem_req_addr), 64'(adr_q.pop_front()));
    end
  end

  initial begin
    bit          hs;
    logic [63:0] bt;
    vif.mem_rsp_valid = 1'b0;
    vif.mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      hs = vif.mem_req_valid && vif.mem_req_ready;
      @(posedge clk);
      #2;
      bt = '0;
      if (hs && beat_q.size() != 0) bt = beat_q.pop_front();
      vif.mem_rsp_valid = hs | stray;
      vif.mem_rsp_data  = W'(bt);
    end
  end

  task automatic expect_rsp(input logic [63:0] d, input logic e, input int l);
    rsp_t r;
    r.data = d; r.err = e; r.lat = l;
    exp_q.push_back(r);
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] op);
    vif.req_addr  = addr;
    vif.req_op    = op;
    vif.req_valid = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vif.req_ready) break;
    end
    check("req accepted", 64'(vif.req_ready), 64'd1);
    @(posedge clk);
    #1;
    vif.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int unsigned i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("rsp queue drained", 64'(exp_q.size()), 64'd0);
    check("bus queue drained", 64'(adr_q.size()), 64'd0);
  endtask

  task automatic check_reset();
    check("reset req_ready", 64'(vif.req_ready), 64'd1);
    check("reset mem_req_valid", 64'(vif.mem_req_valid), 64'd0);
    check("reset mem_req_addr", 64'(vif.mem_req_addr), 64'd0);
    check("reset rsp_valid", 64'(vif.rsp_valid), 64'd0);
    check("reset rsp_data", 64'(vif.rsp_data), 64'd0);
    check("reset rsp_err", 64'(vif.rsp_err), 64'd0);
  endtask

endmodule

// Scoreboard bench for load_align_unit: three instances (32-bit split,
// 32-bit no-split, 64-bit split).
module tb_load_align_unit;

  logic clk;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  load_align_unit_if #(.DATA_W(32)) a_if ();
  load_align_unit_if #(.DATA_W(32)) b_if ();
  load_align_unit_if #(.DATA_W(64)) c_if ();

  lau_agent #(.W(32), .N("a32s")) a (.clk(clk), .vif(a_if));
  lau_agent #(.W(32), .N("b32n")) b (.clk(clk), .vif(b_if));
  lau_agent #(.W(64), .N("c64s")) c (.clk(clk), .vif(c_if));

  load_align_unit #(.DATA_W(32), .SPLIT_EN(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  load_align_unit #(.DATA_W(32), .SPLIT_EN(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  load_align_unit #(.DATA_W(64), .SPLIT_EN(1'b1)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_if.req_valid = 1'b0; a_if.req_addr = '0; a_if.req_op = '0;
    a_if.mem_req_ready = 1'b1; a_if.rsp_ready = 1'b1;
    b_if.req_valid = 1'b0; b_if.req_addr = '0; b_if.req_op = '0;
    b_if.mem_req_ready = 1'b1; b_if.rsp_ready = 1'b1;
    c_if.req_valid = 1'b0; c_if.req_addr = '0; c_if.req_op = '0;
    c_if.mem_req_ready = 1'b1; c_if.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    a.check_reset();
    b.check_reset();
    c.check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // signed HALF inside one word
    a.expect_rsp(64'hFFFF_80FF, 1'b0, 3); a.adr_q.push_back(32'h1000); a.beat_q.push_back(64'h80FF_1234);
    a.load(32'h1002, 5'b00101); a.drain();
    // unsigned WORD split across two beats
    a.expect_rsp(64'h2233_44AA, 1'b0, 5);
    a.adr_q.push_back(32'h1000); a.adr_q.push_back(32'h1004);
    a.beat_q.push_back(64'hAABB_CCDD); a.beat_q.push_back(64'h1122_3344);
    a.load(32'h1003, 5'b00010); a.drain();
    // unsigned BYTE, op[4:3] set and ignored
    a.expect_rsp(64'h0000_0080, 1'b0, 3); a.adr_q.push_back(32'h2000); a.beat_q.push_back(64'h1234_80FF);
    a.load(32'h2001, 5'b11000); a.drain();
    // signed BYTE
    a.expect_rsp(64'hFFFF_FF80, 1'b0, 3); a.adr_q.push_back(32'h2000); a.beat_q.push_back(64'h1234_80FF);
    a.load(32'h2001, 5'b00100); a.drain();
    // signed HALF at last byte of the word: split
    a.expect_rsp(64'hFFFF_C19A, 1'b0, 5);
    a.adr_q.push_back(32'h3000); a.adr_q.push_back(32'h3004);
    a.beat_q.push_back(64'h9A00_0000); a.beat_q.push_back(64'h0000_00C1);
    a.load(32'h3003, 5'b00101); a.drain();
    // DWORD illegal on a 32-bit bus
    a.expect_rsp(64'h0, 1'b1, 1);
    a.load(32'h4000, 5'b00011); a.drain();
    // aligned signed WORD, and unsigned HALF that exactly fits
    a.expect_rsp(64'h8000_0001, 1'b0, 3); a.adr_q.push_back(32'h5000); a.beat_q.push_back(64'h8000_0001);
    a.load(32'h5000, 5'b00110); a.drain();
    a.expect_rsp(64'h0000_BEEF, 1'b0, 3); a.adr_q.push_back(32'h5000); a.beat_q.push_back(64'hBEEF_0000);
    a.load(32'h5002, 5'b00001); a.drain();

    // backpressure on bus request and on result
    a_if.mem_req_ready = 1'b0;
    a_if.rsp_ready     = 1'b0;
    a.expect_rsp(64'h0000_CAFE, 1'b0, 0); a.adr_q.push_back(32'h6000); a.beat_q.push_back(64'h00CA_FE00);
    a.load(32'h6001, 5'b00001);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      check("a32s stall mem_req_valid", 64'(a_if.mem_req_valid), 64'd1);
      check("a32s stall mem_req_addr", 64'(a_if.mem_req_addr), 64'h6000);
      check("a32s stall req_ready", 64'(a_if.req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    a_if.mem_req_ready = 1'b1;
    for (int unsigned i = 0; i < 20 && !a_if.rsp_valid; i++) @(negedge clk);
    check("a32s rsp_valid after stall", 64'(a_if.rsp_valid), 64'd1);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("a32s hold rsp_valid", 64'(a_if.rsp_valid), 64'd1);
      check("a32s hold rsp_data", 64'(a_if.rsp_data), 64'h0000_CAFE);
      check("a32s hold req_ready", 64'(a_if.req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    a_if.rsp_ready = 1'b1;
    a.drain();

    // no-split instance
    b.expect_rsp(64'h0, 1'b1, 1);
    b.load(32'h1001, 5'b00010); b.drain();
    b.expect_rsp(64'h1234_5678, 1'b0, 3); b.adr_q.push_back(32'h1004); b.beat_q.push_back(64'h1234_5678);
    b.load(32'h1004, 5'b00110); b.drain();
    b.expect_rsp(64'h0, 1'b1, 1);
    b.load(32'h2003, 5'b00001); b.drain();

    // 64-bit instance: DWORD wrapping past the top of memory
    c.expect_rsp(64'hCCBB_AA99_8877_6655, 1'b0, 5);
    c.adr_q.push_back(32'hFFFF_FFF8); c.adr_q.push_back(32'h0000_0000);
    c.beat_q.push_back(64'h8877_6655_4433_2211); c.beat_q.push_back(64'h00FF_EEDD_CCBB_AA99);
    c.load(32'hFFFF_FFFC, 5'b00011); c.drain();
    c.expect_rsp(64'hFFFF_FFFF_8000_0000, 1'b0, 3); c.adr_q.push_back(32'h0000_0010);
    c.beat_q.push_back(64'h8000_0000_1234_5678);
    c.load(32'h0000_0014, 5'b00110); c.drain();

    // reset while waiting for the second beat, then a stray response
    a.adr_q.push_back(32'h7000); a.adr_q.push_back(32'h7004);
    a.beat_q.push_back(64'h1111_1111); a.beat_q.push_back(64'h2222_2222);
    a.load(32'h7002, 5'b00010);
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_if.mem_req_valid && a_if.mem_req_ready && a_if.mem_req_addr == 32'h7004) break;
    end
    check("a32s second beat issued", 64'(a_if.mem_req_addr), 64'h7004);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    a.check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a.stray = 1'b1;
    @(posedge clk);
    #1;
    a.stray = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      check("a32s post-reset rsp_valid", 64'(a_if.rsp_valid), 64'd0);
      check("a32s post-reset req_ready", 64'(a_if.req_ready), 64'd1);
      check("a32s post-reset mem_req_valid", 64'(a_if.mem_req_valid), 64'd0);
    end
    a.beat_q.delete();
    @(posedge clk);
    #1;
    a.expect_rsp(64'h0000_007F, 1'b0, 3); a.adr_q.push_back(32'h8000); a.beat_q.push_back(64'h7F00_0000);
    a.load(32'h8003, 5'b00000); a.drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared + a.compared + b.compared + c.compared,
             mismatched + a.mismatched + b.mismatched + c.mismatched);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 Parameter DATA_W, default 32, bus/register width; legal values 32 or 64.
REQ-002 Parameter SPLIT_EN, default 1; 1 = misaligned loads split into two bus beats, 0 = misaligned loads return an error.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid / req_ready  in / out  1 / 1  load request handshake from pipeline.
REQ-006 req_addr  in  32  byte address of load.
REQ-007 req_op  in  5  mem_op; [1:0] size (BYTE, HALF, WORD, DWORD), [2] signed flag, [4:3] ignored.
REQ-008 mem_req_valid / mem_req_ready  out / in  1 / 1  bus request handshake.
REQ-009 mem_req_addr  out  32  bus address, aligned to DATA_W/8 bytes.
REQ-010 mem_rsp_valid / mem_rsp_data  in / in  1 / DATA_W  bus read response; no backpressure.
REQ-011 rsp_valid / rsp_ready  out / in  1 / 1  result handshake to pipeline.
REQ-012 rsp_data  out  DATA_W  aligned, sign/zero-extended load result.
REQ-013 rsp_err  out  1  qualifies rsp_valid; set for an illegal size or an unsplittable misaligned access.

Function
REQ-014 States: IDLE, REQ0, RSP0, REQ1, RSP1, OUT; exactly one request is in flight.
REQ-015 req_ready = 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1, and addr/op are latched.
REQ-016 Bytes B = 1/2/4/8 for size 0/1/2/3; off = addr mod (DATA_W/8); the access is misaligned when off+B > DATA_W/8.
REQ-017 Error cases: size DWORD with DATA_W=32 is illegal; misaligned with SPLIT_EN=0 is an error. Both go IDLE->OUT with rsp_err=1, rsp_data=0, and no bus traffic.
REQ-018 Otherwise IDLE->REQ0; mem_req_valid=1 in REQ0 with mem_req_addr = addr with its low log2(DATA_W/8) bits cleared.
REQ-019 REQ0->RSP0 on mem_req_ready; in RSP0, mem_rsp_valid captures beat0. Next state is REQ1 if misaligned, else OUT.
REQ-020 REQ1 issues mem_req_addr = beat0 address + DATA_W/8, wrapping modulo 2^32. REQ1->RSP1 on mem_req_ready; RSP1->OUT on mem_rsp_valid, capturing beat1.
REQ-021 Result bytes: byte i (i < B) = byte (off+i) of the concatenation {beat1,beat0}; bytes at positions >= B are filled with the sign of byte B-1 if signed, else 0; DWORD ignores the signed flag.
REQ-022 mem_req_valid, once asserted, stays asserted with a stable address until mem_req_ready.
REQ-023 OUT: rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready; OUT->IDLE on rsp_ready.
REQ-024 Minimum latency with mem_req_ready=1 and 1-cycle memory: aligned load, rsp_valid 3 cycles after acceptance; split load, 5 cycles.
REQ-025 A mem_rsp_valid that arrives outside RSP0/RSP1 is ignored.
REQ-026 No new request is accepted in the cycle of OUT->IDLE; back-to-back throughput is one load per latency+1 cycles.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE: req_ready=1, mem_req_valid=0, mem_req_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, and captured beats cleared.
REQ-028 Reset mid-transaction abandons the access; a late mem_rsp_valid after reset release is ignored per REQ-025.

Structure
REQ-029 Shared package holds the MEM_BYTE/HALF/WORD/DWORD size codes, the MEM_SIGNED/MEM_UNSIGNED codes and the state enum typedef.
REQ-030 One sub-module, load_extract, is combinational: {beat1,beat0}, off, size, signed in; extended result out. It is used once for result formatting.

Verification
REQ-031 DATA_W=32, addr 0x1002, op signed HALF, beat0 0x80FF_1234 -> one bus beat at 0x1000, rsp_data 0xFFFF_80FF, rsp_err=0, 3-cycle latency.
REQ-032 DATA_W=32, SPLIT_EN=1, addr 0x1003, unsigned WORD, beat0 0xAABB_CCDD, beat1 0x1122_3344 -> beats at 0x1000 then 0x1004, rsp_data 0x223344AA.
REQ-033 SPLIT_EN=0, addr 0x1001, WORD -> no mem_req_valid, rsp_valid with rsp_err=1, rsp_data=0.
REQ-034 DATA_W=64, addr 0xFFFF_FFFC, unsigned DWORD -> beats at 0xFFFF_FFF8 then 0x0000_0000 (wrap), correct concatenation.
REQ-035 mem_req_ready held 0 for 4 cycles and rsp_ready held 0 for 3 cycles -> mem_req_addr/valid and rsp_data stable throughout, req_ready=0.
REQ-036 rst_n pulsed low in RSP1 -> all outputs at reset values immediately; a stray mem_rsp_valid next cycle produces no rsp_valid.
